// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - ID/EXE hazard detection, stall sequencing and stall/flush event counters
module hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  nReset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  id_early,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_r_en,
    input  logic                  ex_reg_w_en,
    input  logic                  ex_branch_tk,
    input  logic                  cnt_clr,
    output logic                  pc_write_en,
    output logic                  ifid_write_en,
    output logic                  stall,
    output logic                  stall_twice,
    output logic                  flush,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state;
    state_t state_nxt;
    logic   dep;
    logic   hz1;
    logic   hz2;

    // x0 is hardwired to zero, so a write to it never creates a dependency
    always_comb begin
        dep = (ex_rd != '0) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
        hz2 = dep && id_early && ex_mem_r_en;
        hz1 = dep && !hz2 && (ex_mem_r_en || (id_early && ex_reg_w_en));
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = S_IDLE;
        if (state == S_IDLE && !ex_branch_tk && hz2) begin
            state_nxt = S_HOLD;
        end
    end

    // A taken branch overrides any stall, including the second cycle of a two-cycle stall
    always_comb begin
        pc_write_en   = 1'b0;
        ifid_write_en = 1'b0;
        stall         = 1'b0;
        stall_twice   = 1'b0;
        flush         = 1'b0;
        if (nReset) begin
            if (ex_branch_tk) begin
                flush         = 1'b1;
                pc_write_en   = 1'b1;
                ifid_write_en = 1'b1;
            end else if (state == S_HOLD) begin
                stall = 1'b1;
            end else if (hz2) begin
                stall       = 1'b1;
                stall_twice = 1'b1;
            end else if (hz1) begin
                stall = 1'b1;
            end else begin
                pc_write_en   = 1'b1;
                ifid_write_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush && flush_cnt != CNT_MAX) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl against a rule-level reference model
module tb_hazard_ctrl;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] MAXC = '1;

    // expected output vectors {pc_write_en, ifid_write_en, stall, stall_twice, flush}
    localparam logic [4:0] O_RUN   = 5'b11000;
    localparam logic [4:0] O_STALL = 5'b00100;
    localparam logic [4:0] O_TWICE = 5'b00110;
    localparam logic [4:0] O_FLUSH = 5'b11001;
    localparam logic [4:0] O_RST   = 5'b00000;

    logic             clk = 1'b0;
    logic             nReset;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_use_rs1, id_use_rs2, id_early;
    logic             ex_mem_r_en, ex_reg_w_en, ex_branch_tk, cnt_clr;
    logic             pc_write_en, ifid_write_en, stall, stall_twice, flush;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [4:0]       outv;

    int               errors = 0;
    int               checks = 0;
    int               m_remain = 0;
    logic [CNT_W-1:0] m_sc = '0;
    logic [CNT_W-1:0] m_fc = '0;

    hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(CNT_W)) dut (
        .clk(clk), .nReset(nReset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_early(id_early), .ex_rd(ex_rd), .ex_mem_r_en(ex_mem_r_en), .ex_reg_w_en(ex_reg_w_en),
        .ex_branch_tk(ex_branch_tk), .cnt_clr(cnt_clr),
        .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en), .stall(stall),
        .stall_twice(stall_twice), .flush(flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;
    assign outv = {pc_write_en, ifid_write_en, stall, stall_twice, flush};

    // Reference: remaining forced-stall cycles plus the dependency rules on the current inputs
    function automatic logic [4:0] model_out();
        bit dep, h2, h1;
        if (!nReset) return O_RST;
        if (ex_branch_tk) return O_FLUSH;
        if (m_remain > 0) return O_STALL;
        dep = (ex_rd != 0) && ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        h2  = dep && id_early && ex_mem_r_en;
        h1  = dep && !h2 && (ex_mem_r_en || (id_early && ex_reg_w_en));
        if (h2) return O_TWICE;
        if (h1) return O_STALL;
        return O_RUN;
    endfunction

    task automatic advance();
        logic [4:0] e;
        e = model_out();
        @(posedge clk);
        if (!nReset) begin
            m_remain = 0; m_sc = '0; m_fc = '0;
        end else begin
            if (cnt_clr) begin
                m_sc = '0; m_fc = '0;
            end else begin
                if (e[2] && m_sc != MAXC) m_sc = m_sc + 1'b1;
                if (e[0] && m_fc != MAXC) m_fc = m_fc + 1'b1;
            end
            m_remain = e[1] ? 1 : 0;
        end
        #1;
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                         input logic early, input logic [4:0] rd, input logic mr, input logic rw,
                         input logic br);
        id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2; id_early = early;
        ex_rd = rd; ex_mem_r_en = mr; ex_reg_w_en = rw; ex_branch_tk = br;
        #1;
    endtask

    task automatic idle_in();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic clear_counters();
        idle_in();
        cnt_clr = 1'b1;
        advance();
        cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        nReset = 1'b0; cnt_clr = 1'b0;
        drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        checks++;
        if (outv !== O_RST) begin errors++; $display("FAIL reset_outputs got %b exp %b", outv, O_RST); end
        checks++;
        if (stall_cnt !== '0 || flush_cnt !== '0) begin
            errors++; $display("FAIL reset_counters got %0d/%0d exp 0/0", stall_cnt, flush_cnt);
        end
        advance(); advance();
        nReset = 1'b1;
        idle_in();
        checks++;
        if (outv !== O_RUN) begin errors++; $display("FAIL reset_release got %b exp %b", outv, O_RUN); end
    endtask

    task automatic test_load_use();
        clear_counters();
        drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        checks++;
        if (outv !== O_STALL) begin errors++; $display("FAIL load_use_stall got %b exp %b", outv, O_STALL); end
        advance();
        idle_in();
        checks++;
        if (outv !== O_RUN) begin errors++; $display("FAIL load_use_after got %b exp %b", outv, O_RUN); end
        checks++;
        if (stall_cnt !== 8'd1) begin errors++; $display("FAIL load_use_cnt got %0d exp 1", stall_cnt); end
    endtask

    task automatic test_x0();
        clear_counters();
        drive(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (outv !== O_RUN) begin errors++; $display("FAIL x0_outputs got %b exp %b", outv, O_RUN); end
        advance();
        checks++;
        if (stall_cnt !== 8'd0) begin errors++; $display("FAIL x0_cnt got %0d exp 0", stall_cnt); end
    endtask

    task automatic test_load_early();
        clear_counters();
        drive(5'd0, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0);
        checks++;
        if (outv !== O_TWICE) begin errors++; $display("FAIL twice_c0 got %b exp %b", outv, O_TWICE); end
        advance();
        drive(5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              5'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        checks++;
        if (outv !== O_STALL) begin errors++; $display("FAIL twice_c1 got %b exp %b", outv, O_STALL); end
        advance();
        idle_in();
        checks++;
        if (outv !== O_RUN) begin errors++; $display("FAIL twice_c2 got %b exp %b", outv, O_RUN); end
        checks++;
        if (stall_cnt !== 8'd2) begin errors++; $display("FAIL twice_cnt got %0d exp 2", stall_cnt); end
    endtask

    task automatic test_alu_early();
        clear_counters();
        drive(5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0);
        checks++;
        if (outv !== O_STALL) begin errors++; $display("FAIL alu_early_c0 got %b exp %b", outv, O_STALL); end
        advance();
        idle_in();
        checks++;
        if (outv !== O_RUN) begin errors++; $display("FAIL alu_early_c1 got %b exp %b", outv, O_RUN); end
        checks++;
        if (stall_cnt !== 8'd1) begin errors++; $display("FAIL alu_early_cnt got %0d exp 1", stall_cnt); end
    endtask

    task automatic test_branch_in_hold();
        clear_counters();
        drive(5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0);
        advance();
        ex_branch_tk = 1'b1; #1;
        checks++;
        if (outv !== O_FLUSH) begin errors++; $display("FAIL hold_branch got %b exp %b", outv, O_FLUSH); end
        advance();
        idle_in();
        checks++;
        if (outv !== O_RUN) begin errors++; $display("FAIL hold_branch_next got %b exp %b", outv, O_RUN); end
        checks++;
        if (flush_cnt !== 8'd1 || stall_cnt !== 8'd1) begin
            errors++; $display("FAIL hold_branch_cnt got %0d/%0d exp 1/1", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_saturation();
        clear_counters();
        drive(5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < (1 << CNT_W) + 3; i++) advance();
        checks++;
        if (stall_cnt !== MAXC) begin errors++; $display("FAIL sat_cnt got %0d exp %0d", stall_cnt, MAXC); end
        cnt_clr = 1'b1;
        advance();
        cnt_clr = 1'b0;
        checks++;
        if (stall_cnt !== 8'd0) begin errors++; $display("FAIL clr_wins got %0d exp 0", stall_cnt); end
    endtask

    task automatic test_reset_in_hold();
        drive(5'd0, 5'd6, 1'b0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        advance();
        nReset = 1'b0; #1;
        m_remain = 0; m_sc = '0; m_fc = '0;
        checks++;
        if (outv !== O_RST) begin errors++; $display("FAIL hold_reset_out got %b exp %b", outv, O_RST); end
        checks++;
        if (stall_cnt !== '0) begin errors++; $display("FAIL hold_reset_cnt got %0d exp 0", stall_cnt); end
        advance();
        nReset = 1'b1;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
        checks++;
        if (outv !== O_RUN) begin errors++; $display("FAIL hold_reset_idle got %b exp %b", outv, O_RUN); end
    endtask

    task automatic test_random();
        logic [4:0] e;
        for (int i = 0; i < 400; i++) begin
            cnt_clr = ($urandom_range(0, 31) == 0);
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                  1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 7) == 0));
            e = model_out();
            checks++;
            if (outv !== e) begin errors++; $display("FAIL rand_out[%0d] got %b exp %b", i, outv, e); end
            checks++;
            if (stall_cnt !== m_sc || flush_cnt !== m_fc) begin
                errors++;
                $display("FAIL rand_cnt[%0d] got %0d/%0d exp %0d/%0d", i, stall_cnt, flush_cnt, m_sc, m_fc);
            end
            advance();
        end
        cnt_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_x0();
        test_load_early();
        test_alu_early();
        test_branch_in_hold();
        test_saturation();
        test_reset_in_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
